// File: rtl/movegen_sequencer.sv
// movegen_sequencer: drives the chess move-generator core's command port through
// its MVV-LVA search (find victim, then each aggressor of that victim in turn),
// emitting one (from, to) move per handshake. Host commands pass through when idle.
module movegen_sequencer #(
    parameter int RESULT_LAT = 8,   // core edges from FIND-* sample to result edge
    parameter int MAX_AGG    = 16   // aggressor-restore list depth (>= 2)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_data,
    output logic [7:0] core_addr,
    output logic [7:0] core_data,
    input  logic [7:0] core_result,
    output logic       mv_valid,
    input  logic       mv_ready,
    output logic [5:0] mv_from,
    output logic [5:0] mv_to,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic       overflow
);
    localparam int WW = $clog2(RESULT_LAT + 1);
    localparam int LW = $clog2(MAX_AGG + 1);
    localparam int IW = $clog2(MAX_AGG);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RESULT_LAT);
    localparam logic [LW-1:0] LIST_FULL = LW'(MAX_AGG);

    localparam logic [15:0] CMD_NOP      = 16'h0000;
    localparam logic [15:0] CMD_EN_ALL   = 16'hC000;
    localparam logic [15:0] CMD_FIND_VIC = 16'hE000;

    typedef enum logic [3:0] {
        IDLE, EN_ALL, VIC_ISSUE, VIC_WAIT, AGG_ISSUE, AGG_WAIT,
        EMIT, AGG_DIS, RESTORE, VIC_DIS, DONE
    } state_t;

    state_t          state;
    logic [WW-1:0]   wcnt;      // cycles spent waiting for a FIND-* result
    logic [LW-1:0]   lcnt;      // entries held in the aggressor list
    logic [5:0]      victim;
    logic [5:0]      agg_list [MAX_AGG];
    logic [IW-1:0]   push_idx;
    logic [IW-1:0]   pop_idx;

    assign push_idx = IW'(lcnt);
    assign pop_idx  = IW'(lcnt - LW'(1));

    function automatic logic [15:0] cmd_find_agg(input logic [5:0] sq);
        return {4'hF, 2'b00, sq[5:4], sq[3:0], 4'h0};
    endfunction

    function automatic logic [15:0] cmd_set_en(input logic [5:0] sq, input logic v);
        return {4'hD, 2'b00, sq[5:4], sq[3:0], 3'b000, v};
    endfunction

    // Aggressor list storage: each accepted move's aggressor is pushed so it can be re-enabled later
    always_ff @(posedge clk) begin
        if (state == EMIT && mv_ready)
            agg_list[push_idx] <= mv_from;
    end

    // Search FSM; each command is registered on entry to the state that owns it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            core_addr <= 8'h00;
            core_data <= 8'h00;
            mv_valid  <= 1'b0;
            mv_from   <= 6'd0;
            mv_to     <= 6'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            overflow  <= 1'b0;
            victim    <= 6'd0;
            wcnt      <= '0;
            lcnt      <= '0;
        end else begin
            {core_addr, core_data} <= CMD_NOP;
            case (state)
                IDLE: begin
                    {core_addr, core_data} <= {host_addr, host_data};
                    if (start) begin
                        {core_addr, core_data} <= CMD_EN_ALL;
                        busy     <= 1'b1;
                        illegal  <= 1'b0;
                        overflow <= 1'b0;
                        lcnt     <= '0;
                        state    <= EN_ALL;
                    end
                end
                EN_ALL: begin
                    {core_addr, core_data} <= CMD_FIND_VIC;
                    state <= VIC_ISSUE;
                end
                VIC_ISSUE: begin
                    wcnt  <= '0;
                    state <= VIC_WAIT;
                end
                VIC_WAIT: begin
                    if (wcnt != WAIT_LAST) begin
                        wcnt <= wcnt + WW'(1);
                    end else if (core_result[7]) begin
                        illegal <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (core_result[6]) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        victim <= core_result[5:0];
                        {core_addr, core_data} <= cmd_find_agg(core_result[5:0]);
                        state  <= AGG_ISSUE;
                    end
                end
                AGG_ISSUE: begin
                    wcnt  <= '0;
                    state <= AGG_WAIT;
                end
                AGG_WAIT: begin
                    if (wcnt != WAIT_LAST) begin
                        wcnt <= wcnt + WW'(1);
                    end else if (core_result[6]) begin
                        state <= RESTORE;
                    end else begin
                        mv_valid <= 1'b1;
                        mv_from  <= core_result[5:0];
                        mv_to    <= victim;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (mv_ready) begin
                        mv_valid <= 1'b0;
                        {core_addr, core_data} <= cmd_set_en(mv_from, 1'b0);
                        lcnt     <= lcnt + LW'(1);
                        state    <= AGG_DIS;
                    end
                end
                AGG_DIS: begin
                    // a full list stops this victim early; its remaining aggressors are skipped
                    if (lcnt == LIST_FULL) begin
                        overflow <= 1'b1;
                        state    <= RESTORE;
                    end else begin
                        {core_addr, core_data} <= cmd_find_agg(victim);
                        state <= AGG_ISSUE;
                    end
                end
                RESTORE: begin
                    if (lcnt != '0) begin
                        {core_addr, core_data} <= cmd_set_en(agg_list[pop_idx], 1'b1);
                        lcnt <= lcnt - LW'(1);
                    end else begin
                        {core_addr, core_data} <= cmd_set_en(victim, 1'b0);
                        state <= VIC_DIS;
                    end
                end
                VIC_DIS: begin
                    {core_addr, core_data} <= CMD_FIND_VIC;
                    state <= VIC_ISSUE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_movegen_sequencer.sv
// Bench for movegen_sequencer: an abstract move-generator core answers FIND-* commands
// from an attack table and enable mask; expected moves come from a sorted enumeration
// of the same table and are checked by a monitor as the DUT presents them.
module tb_movegen_sequencer;
    localparam int LAT  = 8;
    localparam int MAXA = 4;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, mv_ready = 1'b0;
    logic [7:0] host_addr = 8'h00, host_data = 8'h00, core_result = 8'h00;
    logic [7:0] core_addr, core_data;
    logic       mv_valid, busy, done, illegal, overflow;
    logic [5:0] mv_from, mv_to;

    always #5 clk = ~clk;

    movegen_sequencer #(.RESULT_LAT(LAT), .MAX_AGG(MAXA)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .host_addr(host_addr), .host_data(host_data),
        .core_addr(core_addr), .core_data(core_data), .core_result(core_result),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to),
        .busy(busy), .done(done), .illegal(illegal), .overflow(overflow)
    );

    int total = 0, bad = 0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // board: victim value (-1 none, 7 = king), aggressor value (-1 none), attack table
    int vval[64];
    int aval[64];
    bit att[64][64];
    bit en[64];

    typedef struct { int from; int to; } mv_t;
    typedef struct { int ill; int ovf; int n; } end_t;
    mv_t  exp_mv[$];
    end_t exp_end[$];
    int   mcount = 0;
    int   rdy_mode = 0;    // 0: always ready, 1: random, 2: never
    int   noop_bad = 0;

    task automatic clear_board();
        for (int s = 0; s < 64; s++) begin
            vval[s] = -1;
            aval[s] = -1;
            for (int t = 0; t < 64; t++) att[s][t] = 1'b0;
        end
    endtask

    // our rook on sq0 sweeping the a-file and first rank; sq56 holds their piece of value top
    task automatic rook_board(int top);
        clear_board();
        aval[0] = 4;
        for (int i = 1; i < 8; i++) begin
            vval[i] = 0;     att[0][i] = 1'b1;
            vval[8*i] = 0;   att[0][8*i] = 1'b1;
        end
        vval[56] = top;
    endtask

    task automatic rand_board();
        int sq, nag, nvic;
        clear_board();
        nag  = $urandom_range(1, 6);
        nvic = $urandom_range(0, 7);
        for (int i = 0; i < nag; i++) begin
            do sq = $urandom_range(0, 63); while (aval[sq] >= 0);
            aval[sq] = $urandom_range(0, 6);
        end
        for (int i = 0; i < nvic; i++) begin
            do sq = $urandom_range(0, 63); while (aval[sq] >= 0 || vval[sq] >= 0);
            vval[sq] = $urandom_range(0, 6);
        end
        for (int a = 0; a < 64; a++)
            for (int v = 0; v < 64; v++)
                if (aval[a] >= 0 && vval[v] >= 0) att[a][v] = ($urandom_range(0, 9) < 6);
    endtask

    function automatic int n_att(int v);
        int n = 0;
        for (int a = 0; a < 64; a++) if (aval[a] >= 0 && att[a][v]) n++;
        return n;
    endfunction

    // reference: victims by value high->low (square low->high), each with its
    // attackers by value low->high, at most MAXA per victim
    task automatic expect_run();
        end_t e;
        mv_t  m;
        int   k;
        e.ill = 0; e.ovf = 0; e.n = 0;
        for (int val = 7; val >= 0 && e.ill == 0; val--)
            for (int v = 0; v < 64; v++) begin
                if (vval[v] != val || n_att(v) == 0) continue;
                if (val == 7) begin e.ill = 1; break; end
                k = 0;
                for (int av = 0; av < 8 && k < MAXA; av++)
                    for (int a = 0; a < 64 && k < MAXA; a++)
                        if (aval[a] == av && att[a][v]) begin
                            m.from = a; m.to = v;
                            exp_mv.push_back(m);
                            k++; e.n++;
                        end
                if (k == MAXA) e.ovf = 1;
            end
        exp_end.push_back(e);
    endtask

    // core answers: most valuable enabled victim attacked by an enabled aggressor
    function automatic bit has_en_att(int v);
        for (int a = 0; a < 64; a++) if (en[a] && aval[a] >= 0 && att[a][v]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] find_victim();
        int best = -1, bv = -1;
        logic [5:0] s;
        for (int v = 0; v < 64; v++)
            if (en[v] && vval[v] > bv && has_en_att(v)) begin bv = vval[v]; best = v; end
        if (best < 0) return 8'h40;
        s = best[5:0];
        return (bv == 7) ? {2'b10, s} : {2'b00, s};
    endfunction

    function automatic logic [7:0] find_agg(int v);
        int best = -1, ba = 8;
        logic [5:0] s;
        for (int a = 0; a < 64; a++)
            if (en[a] && aval[a] >= 0 && att[a][v] && aval[a] < ba) begin ba = aval[a]; best = a; end
        if (best < 0) return 8'h40;
        s = best[5:0];
        return {2'b00, s};
    endfunction

    // abstract core: samples the command bus each edge, result shows for one cycle only
    initial begin : core_model
        int ecnt, res_at, noop_until;
        logic [7:0] a, d, res;
        ecnt = 0; res_at = -1; noop_until = -1; res = 8'h00;
        for (int i = 0; i < 64; i++) en[i] = 1'b1;
        forever begin
            @(posedge clk);
            a = core_addr; d = core_data; ecnt++;
            if (ecnt <= noop_until && {a, d} != 16'h0000) noop_bad++;
            if (a == 8'hC0) begin
                for (int i = 0; i < 64; i++) en[i] = 1'b1;
            end else if (a[7:2] == 6'b110100) begin
                en[{a[1:0], d[7:4]}] = d[0];
            end else if (a == 8'hE0 || a[7:2] == 6'b111100) begin
                res = (a == 8'hE0) ? find_victim() : find_agg(int'({a[1:0], d[7:4]}));
                res_at = ecnt + LAT;
                noop_until = ecnt + LAT + 1;
            end
            #1 core_result = (ecnt == res_at) ? res : 8'($urandom);
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk); #1;
            mv_ready = (rdy_mode == 0) ? 1'b1 :
                       (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
        end
    end

    initial begin : monitor
        bit stall;
        logic [5:0] sf, st;
        mv_t  m;
        end_t e;
        stall = 1'b0; sf = '0; st = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin stall = 1'b0; continue; end
            if (stall) begin
                chk("hold_valid", mv_valid, 1);
                chk("hold_from", mv_from, sf);
                chk("hold_to", mv_to, st);
            end
            stall = mv_valid && !mv_ready;
            sf = mv_from; st = mv_to;
            if (mv_valid && mv_ready) begin
                if (exp_mv.size() == 0) chk("extra_move", 1, 0);
                else begin
                    m = exp_mv.pop_front();
                    chk("mv_from", mv_from, m.from);
                    chk("mv_to", mv_to, m.to);
                end
                mcount++;
            end
            if (done) begin
                if (exp_end.size() == 0) chk("extra_done", 1, 0);
                else begin
                    e = exp_end.pop_front();
                    chk("end_illegal", illegal, e.ill);
                    chk("end_overflow", overflow, e.ovf);
                    chk("end_moves", mcount, e.n);
                end
                mcount = 0;
            end
        end
    end

    task automatic pulse_start(int len);
        @(posedge clk); #1 start = 1'b1;
        repeat (len) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(string nm, output int cyc);
        int i = 0;
        while (!done && i < 20000) begin @(negedge clk); i++; end
        chk({nm, "_timeout"}, int'(i < 20000), 1);
        cyc = i;
        @(negedge clk);
        chk({nm, "_busy_low"}, busy, 0);
    endtask

    initial begin : stim
        int i, cyc;
        bit ok;
        logic [7:0] ha, hd;

        // reset with start held high
        rst_n = 1'b0; start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_addr", core_addr, 0);
        chk("reset_data", core_data, 0);
        chk("reset_flags", {mv_valid, busy, done, illegal, overflow}, 0);
        chk("reset_move", {mv_from, mv_to}, 0);
        @(posedge clk); #1 rst_n = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);

        // rook vs queen: command trace and backpressure on the first move
        rook_board(6); expect_run(); rdy_mode = 2;
        pulse_start(1);
        @(negedge clk);
        chk("cmd_en_all", core_addr, 8'hC0);
        chk("busy_rise", busy, 1);
        @(negedge clk);
        chk("cmd_find_vic", core_addr, 8'hE0);
        ok = 1'b1;
        repeat (LAT + 1) begin @(negedge clk); if ({core_addr, core_data} != 16'h0) ok = 1'b0; end
        chk("vic_noop", ok, 1);
        @(negedge clk);
        chk("cmd_find_agg_addr", core_addr, 8'hF3);
        chk("cmd_find_agg_data", core_data, 8'h80);
        i = 0;
        while (!mv_valid && i < 100) begin @(negedge clk); i++; end
        chk("first_valid", mv_valid, 1);
        chk("first_to", mv_to, 56);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!mv_valid || mv_from != 6'd0 || mv_to != 6'd56 || core_addr != 8'h00) ok = 1'b0;
        end
        chk("backpressure", ok, 1);
        rdy_mode = 0;
        wait_done("rook", cyc);

        // their king attacked
        rook_board(7); expect_run();
        pulse_start(1);
        wait_done("illegal", cyc);
        chk("illegal_latency", cyc, LAT + 4);
        chk("illegal_sticky", illegal, 1);

        // nothing of ours on the board
        clear_board(); vval[40] = 1; expect_run();
        pulse_start(1);
        wait_done("nomove", cyc);
        chk("nomove_latency", cyc, LAT + 4);
        chk("illegal_cleared", illegal, 0);

        // list overflow: five attackers on one victim, then a second victim
        clear_board();
        for (int a = 0; a < 5; a++) begin aval[10 + a] = a % 3; att[10 + a][30] = 1'b1; end
        vval[30] = 2; vval[31] = 1; att[12][31] = 1'b1;
        expect_run(); rdy_mode = 1;
        pulse_start(2);
        wait_done("overflow", cyc);

        // reset during AGG_WAIT, reload through the host port, rerun
        rook_board(6); expect_run();
        pulse_start(1);
        i = 0;
        while (core_addr[7:4] != 4'hF && i < 200) begin @(negedge clk); i++; end
        chk("saw_find_agg", core_addr[7:4], 4'hF);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_mv.delete(); exp_end.delete(); mcount = 0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", core_addr, 0);
        chk("midrst_valid", mv_valid, 0);
        repeat (LAT + 4) @(posedge clk);
        repeat (4) begin
            ha = 8'($urandom_range(0, 127)); hd = 8'($urandom);
            @(posedge clk); #1 host_addr = ha; host_data = hd;
            @(posedge clk); @(negedge clk);
            chk("host_addr_pass", core_addr, ha);
            chk("host_data_pass", core_data, hd);
        end
        @(posedge clk); #1 host_addr = 8'h00; host_data = 8'h00;
        repeat (2) @(posedge clk);
        rook_board(6); expect_run(); rdy_mode = 1;
        pulse_start(3);
        wait_done("rerun", cyc);

        // randomized boards with random backpressure
        repeat (12) begin
            rand_board(); expect_run();
            pulse_start($urandom_range(1, 3));
            wait_done("rand", cyc);
        end

        chk("noop_hold", noop_bad, 0);
        chk("queue_drained", exp_mv.size() + exp_end.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
